// File: rtl/dcache_refill.sv
// dcache_refill: line-refill engine for the 1 KB direct-mapped data cache
// (64 lines x 16 bytes, two 64-bit quadwords per line, tag in addr[31:10]).
//
// A miss reported in E1 is latched in IDLE. A line read is requested from the
// memory port, the two returning beats are written into the cache through the
// write_*_xx port, and the pipeline is stalled (refill_busy) until the engine
// returns to IDLE. An invalidate that hits the line being filled suppresses the
// remaining cache writes, but beats are still consumed and the pulses still fire.
//
// Optional feature: define DC_CRITICAL_WORD_FIRST_EN to request the missed
// quadword first (mem_addr[3] = miss addr[3]); otherwise quadword 0 comes first.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   dc_miss_e1          miss strobe (only accepted in IDLE)
//   dc_addr_e1          miss address
//   inv_en_e1           line invalidate strobe
//   inv_index_e1        invalidated line index (addr[9:4])
//   mem_req/mem_addr    line read request, held until mem_ack
//   mem_ack             request accepted
//   mem_rvalid/rdata    returning 64-bit read beats
//   write_xx            cache write strobe
//   write_addr_xx       quadword-aligned cache write address
//   write_data_xx       cache write data
//   write_be_xx         byte enables (8'hFF with every write)
//   refill_busy         pipeline stall, high in every non-IDLE state
//   crit_valid/data     one-cycle pulse carrying the missed quadword
//   refill_done         one-cycle pulse when the refill finishes

`ifndef VA_BITS
`define VA_BITS 32
`endif

module dcache_refill (
    input  logic                clk,
    input  logic                reset,
    input  logic                dc_miss_e1,
    input  logic [`VA_BITS-1:0] dc_addr_e1,
    input  logic                inv_en_e1,
    input  logic [9:4]          inv_index_e1,
    output logic                mem_req,
    output logic [`VA_BITS-1:0] mem_addr,
    input  logic                mem_ack,
    input  logic                mem_rvalid,
    input  logic [63:0]         mem_rdata,
    output logic                write_xx,
    output logic [`VA_BITS-1:0] write_addr_xx,
    output logic [63:0]         write_data_xx,
    output logic [7:0]          write_be_xx,
    output logic                refill_busy,
    output logic                crit_valid,
    output logic [63:0]         crit_data,
    output logic                refill_done
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StBeat0,
        StBeat1,
        StDone
    } state_e;

    state_e                  state_q;
    logic [`VA_BITS-1:4]     line_q;       // line address of the refill
    logic                    miss_qw_q;    // quadword that actually missed
    logic                    first_qw_q;   // quadword returned by the first beat
    logic                    kill_q;       // line invalidated mid-fill

    logic                    mem_req_q;
    logic [`VA_BITS-1:0]     mem_addr_q;
    logic                    write_q;
    logic [`VA_BITS-1:0]     write_addr_q;
    logic [63:0]             write_data_q;
    logic [7:0]              write_be_q;
    logic                    busy_q;
    logic                    crit_valid_q;
    logic [63:0]             crit_data_q;
    logic                    done_q;

    logic                    inv_hit;
    logic                    kill_d;
    logic                    miss_first_qw;
    logic                    beat_take;
    logic                    beat_qw;

    // Byte offset within the quadword never matters to a line refill.
    logic unused_addr_bits;
    assign unused_addr_bits = ^dc_addr_e1[2:0];

    always_comb begin
        inv_hit   = 1'b0;
        kill_d    = kill_q;
        beat_take = 1'b0;
        beat_qw   = 1'b0;

        inv_hit = inv_en_e1 && (inv_index_e1 == line_q[9:4]) && (state_q != StIdle);
        // A hit in the same cycle as a beat already kills that beat's write.
        kill_d  = kill_q | inv_hit;

        beat_take = mem_rvalid && ((state_q == StBeat0) || (state_q == StBeat1));
        // Second beat carries the other quadword of the line (wrap order).
        beat_qw   = first_qw_q ^ (state_q == StBeat1);
    end

`ifdef DC_CRITICAL_WORD_FIRST_EN
    assign miss_first_qw = dc_addr_e1[3];
`else
    assign miss_first_qw = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            line_q       <= '0;
            miss_qw_q    <= 1'b0;
            first_qw_q   <= 1'b0;
            kill_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            write_q      <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            write_be_q   <= 8'h00;
            busy_q       <= 1'b0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            // Pulses default low every cycle.
            write_q      <= 1'b0;
            write_be_q   <= 8'h00;
            crit_valid_q <= 1'b0;
            done_q       <= 1'b0;
            kill_q       <= kill_d;

            if (beat_take) begin
                write_q      <= ~kill_d;
                write_be_q   <= kill_d ? 8'h00 : 8'hFF;
                write_addr_q <= {line_q, beat_qw, 3'b000};
                write_data_q <= mem_rdata;
                // Critical word is reported even when its write is killed.
                if (beat_qw == miss_qw_q) begin
                    crit_valid_q <= 1'b1;
                    crit_data_q  <= mem_rdata;
                end
            end

            unique case (state_q)
                StIdle: begin
                    kill_q <= 1'b0;
                    if (dc_miss_e1) begin
                        line_q     <= dc_addr_e1[`VA_BITS-1:4];
                        miss_qw_q  <= dc_addr_e1[3];
                        first_qw_q <= miss_first_qw;
                        mem_addr_q <= {dc_addr_e1[`VA_BITS-1:4], miss_first_qw, 3'b000};
                        mem_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= StReq;
                    end
                end
                StReq: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= StBeat0;
                    end
                end
                StBeat0: begin
                    if (mem_rvalid) begin
                        state_q <= StBeat1;
                    end
                end
                StBeat1: begin
                    if (mem_rvalid) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    kill_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    kill_q    <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign write_xx      = write_q;
    assign write_addr_xx = write_addr_q;
    assign write_data_xx = write_data_q;
    assign write_be_xx   = write_be_q;
    assign refill_busy   = busy_q;
    assign crit_valid    = crit_valid_q;
    assign crit_data     = crit_data_q;
    assign refill_done   = done_q;

endmodule

// File: tb/tb_dcache_refill.sv
// tb_dcache_refill: directed self-checking bench for dcache_refill.
// Expected cache writes and critical words are queued when a miss is issued
// and compared by a negedge monitor as the DUT produces them.

module tb_dcache_refill;

`ifdef DC_CRITICAL_WORD_FIRST_EN
    localparam bit Cwf = 1'b1;
`else
    localparam bit Cwf = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        dc_miss_e1;
    logic [31:0] dc_addr_e1;
    logic        inv_en_e1;
    logic [9:4]  inv_index_e1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        write_xx;
    logic [31:0] write_addr_xx;
    logic [63:0] write_data_xx;
    logic [7:0]  write_be_xx;
    logic        refill_busy;
    logic        crit_valid;
    logic [63:0] crit_data;
    logic        refill_done;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [63:0] exp_crit[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    dcache_refill dut (
        .clk           (clk),
        .reset         (reset),
        .dc_miss_e1    (dc_miss_e1),
        .dc_addr_e1    (dc_addr_e1),
        .inv_en_e1     (inv_en_e1),
        .inv_index_e1  (inv_index_e1),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .write_xx      (write_xx),
        .write_addr_xx (write_addr_xx),
        .write_data_xx (write_data_xx),
        .write_be_xx   (write_be_xx),
        .refill_busy   (refill_busy),
        .crit_valid    (crit_valid),
        .crit_data     (crit_data),
        .refill_done   (refill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish within 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: first beat is qw f, second beat is ~f; crit is the beat whose qw
    // matches miss addr[3]. kill1 drops the second write (invalidate/reset).
    task automatic push_line(input logic [31:0] a, input logic [63:0] d0,
                             input logic [63:0] d1, input bit kill1);
        logic        f;
        logic [31:0] base;
        f    = Cwf ? a[3] : 1'b0;
        base = {a[31:4], 4'b0000};
        exp_wr.push_back('{base | {28'b0, f, 3'b000}, d0});
        if (!kill1) exp_wr.push_back('{base | {28'b0, ~f, 3'b000}, d1});
        exp_crit.push_back((f == a[3]) ? d0 : d1);
    endtask

    always @(negedge clk) begin : monitor
        wr_t         e;
        logic [63:0] c;
        if (write_xx) begin
            check("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
            if (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                check("wr_addr", 64'(write_addr_xx), 64'(e.addr));
                check("wr_data", write_data_xx, e.data);
                check("wr_be", 64'(write_be_xx), 64'hFF);
            end
        end
        if (crit_valid) begin
            check("crit_expected", 64'(exp_crit.size() != 0), 64'd1);
            if (exp_crit.size() != 0) begin
                c = exp_crit.pop_front();
                check("crit_data", crit_data, c);
            end
        end
    end

    task automatic check_drained(input string tag);
        check({tag, "_wr_drained"}, 64'(exp_wr.size()), 64'd0);
        check({tag, "_crit_drained"}, 64'(exp_crit.size()), 64'd0);
    endtask

    initial begin
        bit found;
        reset = 1'b1; dc_miss_e1 = 1'b0; dc_addr_e1 = '0; inv_en_e1 = 1'b0;
        inv_index_e1 = '0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_maddr", 64'(mem_addr), 64'd0);
        check("rst_wr", 64'(write_xx), 64'd0);
        check("rst_be", 64'(write_be_xx), 64'd0);
        check("rst_busy", 64'(refill_busy), 64'd0);
        check("rst_crit", 64'(crit_valid), 64'd0);
        check("rst_done", 64'(refill_done), 64'd0);
        reset = 1'b0;

        // T1: minimum-latency refill of 0x1238.
        dc_miss_e1 = 1'b1; dc_addr_e1 = 32'h1238;
        push_line(32'h1238, 64'hA, 64'hB, 1'b0);
        tick();
        dc_miss_e1 = 1'b0;
        check("t1_busy", 64'(refill_busy), 64'd1);
        check("t1_req", 64'(mem_req), 64'd1);
        check("t1_maddr", 64'(mem_addr), Cwf ? 64'h1238 : 64'h1230);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t1_req_drop", 64'(mem_req), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 64'hA;
        tick();
        mem_rdata = 64'hB;
        check("t1_done_early", 64'(refill_done), 64'd0);
        tick();
        mem_rvalid = 1'b0;
        check("t1_done", 64'(refill_done), 64'd1);
        check("t1_busy_done", 64'(refill_busy), 64'd1);
        tick();
        check("t1_done_pulse", 64'(refill_done), 64'd0);
        check("t1_busy_low", 64'(refill_busy), 64'd0);
        check_drained("t1");

        // T2: ack delayed 5 cycles, gap between beats.
        dc_miss_e1 = 1'b1; dc_addr_e1 = 32'h4560;
        push_line(32'h4560, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0);
        tick();
        dc_miss_e1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t2_req_held", 64'(mem_req), 64'd1);
            check("t2_maddr_held", 64'(mem_addr), 64'h4560);
            check("t2_no_write", 64'(write_xx), 64'd0);
            tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t2_req_drop", 64'(mem_req), 64'd0);
        tick();
        check("t2_no_write_b0", 64'(write_xx), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
        tick();
        mem_rvalid = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 64'h5555_6666_7777_8888;
        tick();
        mem_rvalid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            if (refill_done) found = 1'b1;
            else tick();
        end
        check("t2_done_seen", 64'(found), 64'd1);
        tick();
        check("t2_busy_low", 64'(refill_busy), 64'd0);
        check_drained("t2");

        // T3: invalidate index 0x23 between beats of the 0x1230 refill.
        dc_miss_e1 = 1'b1; dc_addr_e1 = 32'h1230;
        push_line(32'h1230, 64'hC, 64'hD, 1'b1);
        tick();
        dc_miss_e1 = 1'b0;
        inv_en_e1 = 1'b1; inv_index_e1 = 6'h24;  // different line: no effect
        mem_ack = 1'b1;
        tick();
        inv_en_e1 = 1'b0; mem_ack = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hC;
        tick();
        mem_rvalid = 1'b0;
        inv_en_e1 = 1'b1; inv_index_e1 = 6'h23;
        tick();
        inv_en_e1 = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hD;
        tick();
        mem_rvalid = 1'b0;
        check("t3_done", 64'(refill_done), 64'd1);
        check("t3_killed_write", 64'(write_xx), 64'd0);
        tick();
        check("t3_busy_low", 64'(refill_busy), 64'd0);
        check("t3_done_pulse", 64'(refill_done), 64'd0);
        check_drained("t3");

        // T4: reset in BEAT1, stray beat afterwards, then a clean miss.
        dc_miss_e1 = 1'b1; dc_addr_e1 = 32'h2000;
        push_line(32'h2000, 64'hE, 64'hF, 1'b1);
        tick();
        dc_miss_e1 = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hE;
        tick();
        mem_rvalid = 1'b0;
        reset = 1'b1;
        tick();
        check("t4_rst_req", 64'(mem_req), 64'd0);
        check("t4_rst_maddr", 64'(mem_addr), 64'd0);
        check("t4_rst_wr", 64'(write_xx), 64'd0);
        check("t4_rst_waddr", 64'(write_addr_xx), 64'd0);
        check("t4_rst_wdata", write_data_xx, 64'd0);
        check("t4_rst_be", 64'(write_be_xx), 64'd0);
        check("t4_rst_busy", 64'(refill_busy), 64'd0);
        check("t4_rst_crit", 64'(crit_valid), 64'd0);
        check("t4_rst_critd", crit_data, 64'd0);
        check("t4_rst_done", 64'(refill_done), 64'd0);
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hF;
        tick();
        mem_rvalid = 1'b0;
        check("t4_stray_wr", 64'(write_xx), 64'd0);
        check("t4_stray_busy", 64'(refill_busy), 64'd0);
        check("t4_stray_req", 64'(mem_req), 64'd0);
        dc_miss_e1 = 1'b1; dc_addr_e1 = 32'h3008;
        push_line(32'h3008, 64'h77, 64'h88, 1'b0);
        tick();
        dc_miss_e1 = 1'b0;
        check("t4_new_req", 64'(mem_req), 64'd1);
        check("t4_new_maddr", 64'(mem_addr), Cwf ? 64'h3008 : 64'h3000);
        check("t4_new_busy", 64'(refill_busy), 64'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'h77;
        tick();
        mem_rdata = 64'h88;
        tick();
        mem_rvalid = 1'b0;
        check("t4_done", 64'(refill_done), 64'd1);
        tick();
        check("t4_busy_low", 64'(refill_busy), 64'd0);
        check_drained("t4");

        // T5: miss held high across a refill, re-issued on re-entering IDLE.
        dc_miss_e1 = 1'b1; dc_addr_e1 = 32'h5000;
        push_line(32'h5000, 64'h51, 64'h52, 1'b0);
        tick();
        check("t5_req", 64'(mem_req), 64'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'h51;
        check("t5_req_b0", 64'(mem_req), 64'd0);
        tick();
        mem_rdata = 64'h52;
        check("t5_req_b1", 64'(mem_req), 64'd0);
        tick();
        mem_rvalid = 1'b0;
        check("t5_done", 64'(refill_done), 64'd1);
        check("t5_req_done", 64'(mem_req), 64'd0);
        tick();
        check("t5_idle_busy", 64'(refill_busy), 64'd0);
        check("t5_idle_req", 64'(mem_req), 64'd0);
        push_line(32'h5000, 64'h61, 64'h62, 1'b0);
        tick();
        dc_miss_e1 = 1'b0;
        check("t5_req2", 64'(mem_req), 64'd1);
        check("t5_busy2", 64'(refill_busy), 64'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'h61;
        tick();
        mem_rdata = 64'h62;
        tick();
        mem_rvalid = 1'b0;
        check("t5_done2", 64'(refill_done), 64'd1);
        tick();
        check("t5_busy_low2", 64'(refill_busy), 64'd0);
        check_drained("t5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
